// File: rtl/mdc_fifo_reader.sv
// Read-side adapter for an MDC small FIFO: pops through valid/enr, buffers two
// tokens and re-presents them as a valid/ready stream with per-packet last marking.
module mdc_fifo_reader #(
  parameter int DATA_W  = 8,
  parameter int PKT_LEN = 16,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              fifo_valid,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_enr,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  pkt_cnt
);

  localparam int IDX_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PKT_LEN - 1);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_TWO
  } occ_t;

  occ_t              r_occ;
  occ_t              w_occ_nxt;
  logic              r_guard;
  logic [IDX_W-1:0]  r_in_idx;
  logic [DATA_W-1:0] r_head_data;
  logic [DATA_W-1:0] r_tail_data;
  logic              r_head_last;
  logic              r_tail_last;
  logic [CNT_W-1:0]  r_pkt_cnt;

  logic              w_pop;
  logic              w_emit;
  logic              w_in_last;
  logic              w_head_ld_in;
  logic              w_head_ld_tail;
  logic              w_tail_ld;

  // The guard masks the cycle after a pop, where the FIFO's flag is still stale.
  // rst is folded in so the strobe drops the moment reset asserts.
  assign w_pop     = rst & fifo_valid & ~r_guard & ~clr & (r_occ != S_TWO);
  assign w_emit    = m_valid & m_ready;
  assign w_in_last = (r_in_idx == IDX_MAX);

  assign fifo_enr  = w_pop;
  assign m_valid   = (r_occ != S_EMPTY);
  assign m_data    = r_head_data;
  assign m_last    = r_head_last;
  assign pkt_cnt   = r_pkt_cnt;

  always_comb begin
    w_occ_nxt      = r_occ;
    w_head_ld_in   = 1'b0;
    w_head_ld_tail = 1'b0;
    w_tail_ld      = 1'b0;
    case (r_occ)
      S_EMPTY: begin
        if (w_pop) begin
          w_occ_nxt    = S_ONE;
          w_head_ld_in = 1'b1;
        end
      end
      S_ONE: begin
        if (w_pop && w_emit) begin
          w_head_ld_in = 1'b1;
        end else if (w_pop) begin
          w_occ_nxt = S_TWO;
          w_tail_ld = 1'b1;
        end else if (w_emit) begin
          w_occ_nxt = S_EMPTY;
        end
      end
      S_TWO: begin
        if (w_emit) begin
          w_occ_nxt      = S_ONE;
          w_head_ld_tail = 1'b1;
        end
      end
      default: w_occ_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_occ       <= S_EMPTY;
      r_guard     <= 1'b0;
      r_in_idx    <= '0;
      r_pkt_cnt   <= '0;
      r_head_data <= '0;
      r_head_last <= 1'b0;
      r_tail_data <= '0;
      r_tail_last <= 1'b0;
    end else if (clr) begin
      r_occ       <= S_EMPTY;
      r_guard     <= 1'b0;
      r_in_idx    <= '0;
      r_pkt_cnt   <= '0;
      r_head_data <= '0;
      r_head_last <= 1'b0;
      r_tail_data <= '0;
      r_tail_last <= 1'b0;
    end else begin
      r_occ   <= w_occ_nxt;
      r_guard <= w_pop;
      if (w_pop) begin
        r_in_idx <= w_in_last ? '0 : r_in_idx + 1'b1;
      end
      if (w_emit && r_head_last) begin
        r_pkt_cnt <= r_pkt_cnt + 1'b1;
      end
      if (w_head_ld_in) begin
        r_head_data <= fifo_data;
        r_head_last <= w_in_last;
      end else if (w_head_ld_tail) begin
        r_head_data <= r_tail_data;
        r_head_last <= r_tail_last;
      end
      if (w_tail_ld) begin
        r_tail_data <= fifo_data;
        r_tail_last <= w_in_last;
      end
    end
  end

endmodule
